// File: rtl/gam_winner_search.sv
// gam_winner_search
//   Scans the stored prototypes of one class against an input vector using
//   Manhattan distance and finds the nearest (winner1) and second-nearest
//   (winner2) occupied slots. It then issues a one-cycle en_connection pulse
//   so the connection memory can create or refresh the winner1-winner2 edge.
//   If no usable pair exists, or winner1 is farther than thr, it issues a
//   one-cycle ins_req pulse instead.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   start/ready    request handshake; a request is accepted when start&ready
//   x_in           input vector, element i at [i*DATA_W +: DATA_W]
//   class_in       class to search
//   thr            maximum winner1 distance that still allows a connection
//   learning_done  when high in DONE, suppresses en_connection/ins_req
//   node_rd_*      prototype memory read port (1-cycle read latency)
//   node1, node2   winner indices (0 = none)
//   dist1          winner1 distance (all-ones = none)
//   class_i        latched class
//   res_valid      one-cycle result strobe
//   en_connection  one-cycle edge create/refresh request
//   ins_req        one-cycle node insertion request
module gam_winner_search #(
  parameter int NODE_COUNT  = 16,
  parameter int DIM         = 4,
  parameter int DATA_W      = 8,
  parameter int CLASS_COUNT = 4,
  localparam int NW = $clog2(NODE_COUNT),
  localparam int CW = $clog2(CLASS_COUNT),
  localparam int DW = DATA_W + $clog2(DIM) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  ready,
  input  logic [DIM*DATA_W-1:0] x_in,
  input  logic [CW-1:0]         class_in,
  input  logic [DW-1:0]         thr,
  input  logic                  learning_done,
  output logic                  node_rd_en,
  output logic [CW+NW-1:0]      node_rd_addr,
  input  logic [DIM*DATA_W-1:0] node_rd_data,
  input  logic                  node_rd_valid,
  output logic [NW-1:0]         node1,
  output logic [NW-1:0]         node2,
  output logic [DW-1:0]         dist1,
  output logic [CW-1:0]         class_i,
  output logic                  res_valid,
  output logic                  en_connection,
  output logic                  ins_req
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [DIM*DATA_W-1:0] x_q;
  logic [DW-1:0]         thr_q;
  logic [NW-1:0]         addr_p0;
  logic [NW-1:0]         idx_p1;
  logic                  vld_p1;

  logic [DW-1:0] best_q, second_q, best_nxt, second_nxt;
  logic [NW-1:0] idx1_q, idx2_q, idx1_nxt, idx2_nxt;
  logic [1:0]    vcnt_q, vcnt_nxt;
  logic [DW-1:0] dist_p1;

  wire accept = (state == S_IDLE) && start;

  // Sum of absolute element differences; DW leaves room for DIM full-scale terms.
  function automatic logic [DW-1:0] manhattan(input logic [DIM*DATA_W-1:0] a,
                                               input logic [DIM*DATA_W-1:0] b);
    logic [DW-1:0]     acc;
    logic [DATA_W-1:0] ea, eb, diff;
    acc = '0;
    for (int i = 0; i < DIM; i++) begin
      ea   = a[i*DATA_W +: DATA_W];
      eb   = b[i*DATA_W +: DATA_W];
      diff = (ea > eb) ? (ea - eb) : (eb - ea);
      acc  = acc + DW'(diff);
    end
    return acc;
  endfunction

  // ---- stage p0: read issue ----
  assign node_rd_en   = (state == S_SCAN);
  assign node_rd_addr = {class_i, addr_p0};

  // ---- stage p1: read return, distance and winner update ----
  // Strict '<' with an ascending scan means equal distances keep the lower index.
  always_comb begin
    best_nxt   = best_q;
    second_nxt = second_q;
    idx1_nxt   = idx1_q;
    idx2_nxt   = idx2_q;
    vcnt_nxt   = vcnt_q;
    dist_p1    = manhattan(x_q, node_rd_data);
    if (vld_p1 && node_rd_valid) begin
      if (vcnt_q != 2'd2) vcnt_nxt = vcnt_q + 2'd1;
      if (dist_p1 < best_q) begin
        second_nxt = best_q;
        idx2_nxt   = idx1_q;
        best_nxt   = dist_p1;
        idx1_nxt   = idx_p1;
      end else if (dist_p1 < second_q) begin
        second_nxt = dist_p1;
        idx2_nxt   = idx_p1;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    ready         = 1'b0;
    res_valid     = 1'b0;
    en_connection = 1'b0;
    ins_req       = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = S_SCAN;
      end
      S_SCAN: begin
        if (addr_p0 == NW'(NODE_COUNT - 1)) state_nxt = S_DRAIN;
      end
      S_DRAIN: state_nxt = S_DONE;
      S_DONE: begin
        res_valid = 1'b1;
        if (!learning_done) begin
          if ((vcnt_q == 2'd2) && (best_q <= thr_q)) en_connection = 1'b1;
          else                                       ins_req       = 1'b1;
        end
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      vld_p1  <= 1'b0;
      node1   <= '0;
      node2   <= '0;
      dist1   <= '1;
      class_i <= '0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= (state == S_SCAN);
      if (accept) class_i <= class_in;
      // The last word is folded in on the DRAIN edge, so publish the merged result.
      if (state == S_DRAIN) begin
        node1 <= idx1_nxt;
        node2 <= idx2_nxt;
        dist1 <= best_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    idx_p1 <= addr_p0;
    if (accept) begin
      x_q      <= x_in;
      thr_q    <= thr;
      best_q   <= '1;
      second_q <= '1;
      idx1_q   <= '0;
      idx2_q   <= '0;
      vcnt_q   <= 2'd0;
      addr_p0  <= NW'(1);
    end else begin
      best_q   <= best_nxt;
      second_q <= second_nxt;
      idx1_q   <= idx1_nxt;
      idx2_q   <= idx2_nxt;
      vcnt_q   <= vcnt_nxt;
      if (state == S_SCAN) addr_p0 <= addr_p0 + NW'(1);
    end
  end

endmodule

// File: tb/tb_gam_winner_search.sv
// tb_gam_winner_search
//   Bench for gam_winner_search with NODE_COUNT=4, DIM=2, DATA_W=8, CLASS_COUNT=4.
//   A behavioural prototype memory answers reads one cycle later. A reference
//   function ranks occupied nodes by (distance, index) to predict the results.
module tb_gam_winner_search;
  localparam int NC = 4;
  localparam int DIM = 2;
  localparam int DATA_W = 8;
  localparam int CC = 4;
  localparam int NW = 2;
  localparam int CW = 2;
  localparam int DW = 10;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  ready;
  logic [DIM*DATA_W-1:0] x_in;
  logic [CW-1:0]         class_in;
  logic [DW-1:0]         thr;
  logic                  learning_done;
  logic                  node_rd_en;
  logic [CW+NW-1:0]      node_rd_addr;
  logic [DIM*DATA_W-1:0] node_rd_data;
  logic                  node_rd_valid;
  logic [NW-1:0]         node1, node2;
  logic [DW-1:0]         dist1;
  logic [CW-1:0]         class_i;
  logic                  res_valid, en_connection, ins_req;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem_e0 [CC][NC];
  logic [7:0] mem_e1 [CC][NC];
  logic       mem_v  [CC][NC];

  gam_winner_search #(
    .NODE_COUNT(NC), .DIM(DIM), .DATA_W(DATA_W), .CLASS_COUNT(CC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .x_in(x_in),
    .class_in(class_in), .thr(thr), .learning_done(learning_done),
    .node_rd_en(node_rd_en), .node_rd_addr(node_rd_addr),
    .node_rd_data(node_rd_data), .node_rd_valid(node_rd_valid),
    .node1(node1), .node2(node2), .dist1(dist1), .class_i(class_i),
    .res_valid(res_valid), .en_connection(en_connection), .ins_req(ins_req)
  );

  always #5 clk = ~clk;

  // Prototype memory with one cycle of read latency.
  always @(posedge clk) begin
    if (node_rd_en) begin
      node_rd_data  <= {mem_e1[node_rd_addr[3:2]][node_rd_addr[1:0]],
                        mem_e0[node_rd_addr[3:2]][node_rd_addr[1:0]]};
      node_rd_valid <= mem_v[node_rd_addr[3:2]][node_rd_addr[1:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Winner1 is the minimum by (distance, index); winner2 the minimum of the rest.
  task automatic model(input logic [15:0] xv, input int cls, input int th, input bit ld,
                       output int n1, output int n2, output int d1,
                       output bit en, output bit ins);
    int bd, sd, cnt, d;
    n1 = 0; n2 = 0; bd = 0; sd = 0; cnt = 0;
    for (int n = 1; n < NC; n++) begin
      if (mem_v[cls][n]) begin
        cnt++;
        d = absdiff(int'(xv[7:0]), int'(mem_e0[cls][n])) + absdiff(int'(xv[15:8]), int'(mem_e1[cls][n]));
        if (n1 == 0 || d < bd) begin bd = d; n1 = n; end
      end
    end
    for (int n = 1; n < NC; n++) begin
      if (mem_v[cls][n] && n != n1) begin
        d = absdiff(int'(xv[7:0]), int'(mem_e0[cls][n])) + absdiff(int'(xv[15:8]), int'(mem_e1[cls][n]));
        if (n2 == 0 || d < sd) begin sd = d; n2 = n; end
      end
    end
    d1  = (n1 != 0) ? bd : 1023;
    en  = !ld && cnt >= 2 && bd <= th;
    ins = !ld && !(cnt >= 2 && bd <= th);
  endtask

  task automatic set_node(input int cls, input int n, input int e0, input int e1, input bit v);
    mem_e0[cls][n] = 8'(e0);
    mem_e1[cls][n] = 8'(e1);
    mem_v[cls][n]  = v;
  endtask

  task automatic wait_ready();
    int w = 0;
    while (!ready && w < 50) begin @(negedge clk); w++; end
    check("ready_wait", 32'(ready), 1);
  endtask

  task automatic run_txn(input string tag, input logic [15:0] xv, input int cls,
                         input int th, input bit ld, input bit busy_start);
    int  n1, n2, d1, cyc, extra, early;
    bit  en, ins, got;
    model(xv, cls, th, ld, n1, n2, d1, en, ins);
    wait_ready();
    x_in = xv; class_in = CW'(cls); thr = DW'(th); learning_done = ld; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Anything driven now must not affect the accepted request.
    start = busy_start; x_in = 16'($urandom); class_in = CW'($urandom); thr = DW'($urandom);
    cyc = 1; got = 0; early = 0;
    while (cyc <= 12) begin
      if (res_valid) begin got = 1; break; end
      if (en_connection || ins_req) early++;
      @(negedge clk);
      cyc++;
      if (cyc == 2) start = 1'b0;
    end
    check({tag, ".latency"}, 32'(cyc), NC + 1);
    check({tag, ".early_pulse"}, 32'(early), 0);
    check({tag, ".node1"}, 32'(node1), 32'(n1));
    check({tag, ".node2"}, 32'(node2), 32'(n2));
    check({tag, ".dist1"}, 32'(dist1), 32'(d1));
    check({tag, ".class_i"}, 32'(class_i), 32'(cls));
    check({tag, ".en_connection"}, 32'(en_connection), 32'(en));
    check({tag, ".ins_req"}, 32'(ins_req), 32'(ins));
    @(negedge clk);
    check({tag, ".pulse_end"}, {29'd0, res_valid, en_connection, ins_req}, 0);
    check({tag, ".ready_after"}, 32'(ready), 1);
    if (busy_start) begin
      extra = 0;
      for (int i = 0; i < NC + 3; i++) begin
        if (res_valid || node_rd_en) extra++;
        @(negedge clk);
      end
      check({tag, ".no_queue"}, 32'(extra), 0);
    end
  endtask

  task automatic load_t1();
    set_node(0, 0, 0, 0, 0);
    set_node(0, 1, 0, 0, 1);
    set_node(0, 2, 12, 9, 1);
    set_node(0, 3, 50, 50, 1);
  endtask

  initial begin
    int pulses, reads;
    for (int c = 0; c < CC; c++)
      for (int n = 0; n < NC; n++) set_node(c, n, 0, 0, 0);
    rst = 1'b1; start = 1'b0; x_in = '0; class_in = '0; thr = '0; learning_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.ready", 32'(ready), 1);
    check("rst.node1", 32'(node1), 0);
    check("rst.node2", 32'(node2), 0);
    check("rst.dist1", 32'(dist1), 1023);
    check("rst.class_i", 32'(class_i), 0);
    check("rst.pulses", {28'd0, res_valid, en_connection, ins_req, node_rd_en}, 0);
    rst = 1'b0;
    @(negedge clk);

    // T1: nearest node 2 (d=3), second node 1 (d=20), connection.
    load_t1();
    run_txn("T1", {8'd10, 8'd10}, 0, 100, 0, 0);
    // T2: equal distances keep the lower index as winner1.
    set_node(1, 1, 5, 10, 1);
    set_node(1, 2, 15, 10, 1);
    set_node(1, 3, 0, 0, 0);
    run_txn("T2", {8'd10, 8'd10}, 1, 100, 0, 0);
    // T3: single valid node -> insertion.
    set_node(2, 1, 0, 0, 0);
    set_node(2, 2, 0, 0, 0);
    set_node(2, 3, 14, 13, 1);
    run_txn("T3", {8'd10, 8'd10}, 2, 100, 0, 0);
    // T4: winner too far for the threshold.
    run_txn("T4", {8'd10, 8'd10}, 0, 2, 0, 0);
    // T4b: threshold equal to the distance still connects.
    run_txn("T4b", {8'd10, 8'd10}, 0, 3, 0, 0);
    // T5: learning finished, result only.
    run_txn("T5", {8'd10, 8'd10}, 0, 100, 1, 0);
    // No valid nodes at all.
    run_txn("empty", {8'd1, 8'd2}, 3, 100, 0, 1);

    // T6: start while busy, then reset mid-scan.
    wait_ready();
    x_in = {8'd10, 8'd10}; class_in = 2'd0; thr = 10'd100; learning_done = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("T6.ready", 32'(ready), 1);
    check("T6.node1", 32'(node1), 0);
    check("T6.dist1", 32'(dist1), 1023);
    pulses = 0; reads = 0;
    for (int i = 0; i < 10; i++) begin
      if (res_valid || en_connection || ins_req) pulses++;
      if (node_rd_en) reads++;
      @(negedge clk);
    end
    check("T6.no_pulse", 32'(pulses), 0);
    check("T6.no_scan", 32'(reads), 0);

    // Randomized transactions; small value ranges provoke distance ties.
    for (int t = 0; t < 150; t++) begin
      bit narrow;
      int cls;
      narrow = $urandom_range(0, 1);
      for (int c = 0; c < CC; c++)
        for (int n = 0; n < NC; n++)
          set_node(c, n,
                   narrow ? $urandom_range(0, 7) : $urandom_range(0, 255),
                   narrow ? $urandom_range(0, 7) : $urandom_range(0, 255),
                   $urandom_range(0, 3) != 0);
      cls = $urandom_range(0, CC - 1);
      run_txn($sformatf("R%0d", t),
              narrow ? {8'($urandom_range(0, 7)), 8'($urandom_range(0, 7))} : 16'($urandom),
              cls,
              narrow ? $urandom_range(0, 8) : $urandom_range(0, 300),
              $urandom_range(0, 7) == 0,
              $urandom_range(0, 9) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
